// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles little-endian 32-bit words from a
// byte stream, writes them to consecutive addresses from 0, and holds the
// processor core in reset until the whole program has been written.
module imem_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    // Wide enough for N = 256 and for word_count, whichever is larger.
    localparam int unsigned NW = (ADDR_WIDTH + 1 > 9) ? ADDR_WIDTH + 1 : 9;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StData,
        StWrite,
        StDone,
        StErr
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic [NW-1:0]         n_q, n_d;
    logic [1:0]            byte_idx_q, byte_idx_d;

    logic          xfer;
    logic [NW-1:0] hdr_n;
    logic          too_many;
    logic          last_word;

    // Handshake and state-decoded status outputs.
    always_comb begin
        byte_ready = (state_q == StHdr) || (state_q == StData);
        wr_en      = (state_q == StWrite);
        done       = (state_q == StDone);
        error      = (state_q == StErr);
        core_hold  = (state_q != StDone);
        wr_addr    = wr_addr_q;
        wr_data    = wr_data_q;
        word_count = word_count_q;
        xfer       = byte_valid && byte_ready;
        hdr_n      = NW'(byte_data) + NW'(1);
        too_many   = (32'(hdr_n) > Depth);
        last_word  = ((NW'(word_count_q) + NW'(1)) == n_q);
    end

    // Next-state logic for the load sequencer and its datapath registers.
    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        word_count_d = word_count_q;
        n_d          = n_q;
        byte_idx_d   = byte_idx_q;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StHdr;
            end
            StHdr: begin
                if (xfer) begin
                    n_d = hdr_n;
                    if (too_many) begin
                        state_d = StErr;
                    end else begin
                        state_d      = StData;
                        wr_addr_d    = '0;
                        word_count_d = '0;
                        byte_idx_d   = '0;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    wr_data_d[8*byte_idx_q +: 8] = byte_data;
                    byte_idx_d                   = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) state_d = StWrite;
                end
            end
            StWrite: begin
                word_count_d = word_count_q + 1'b1;
                // The final address is left in place so it never wraps.
                if (last_word) begin
                    state_d = StDone;
                end else begin
                    wr_addr_d = wr_addr_q + 1'b1;
                    state_d   = StData;
                end
            end
            StDone, StErr: begin
                if (start) state_d = StHdr;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            word_count_q <= '0;
            n_q          <= '0;
            byte_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            word_count_q <= word_count_d;
            n_q          <= n_d;
            byte_idx_q   <= byte_idx_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected writes, a
// monitor pops and compares on every wr_en; status checks are inline.
module tb_imem_loader;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        core_hold;
    logic        done;
    logic        error;
    logic [6:0]  word_count;

    imem_loader #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(6)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .core_hold (core_hold),
        .done      (done),
        .error     (error),
        .word_count(word_count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (!RST && wr_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_wr: addr %0d data 0x%08h, no write expected",
                         wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                check("wr_data", wr_data, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Holds the byte until it is accepted; returns at the negedge after transfer.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t          = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: byte_ready stayed 0, expected 1");
        end
        tick();
    endtask

    task automatic send_word(input logic [5:0] a, input logic [31:0] w);
        exp_q.push_back({a, w});
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic stop();
        byte_valid = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (!done && !error && t < 50) begin
            tick();
            t++;
        end
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_core_hold"}, 32'(core_hold), 32'd0);
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_ready"}, 32'(byte_ready), 32'd0);
        check({name, "_wr_en"}, 32'(wr_en), 32'd0);
        check({name, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({name, "_wr_data"}, wr_data, 32'd0);
        check({name, "_core_hold"}, 32'(core_hold), 32'd1);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_error"}, 32'(error), 32'd0);
        check({name, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    logic [31:0] prog[3];

    initial begin
        RST        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        prog[0]    = 32'h00500093;
        prog[1]    = 32'h00A00113;
        prog[2]    = 32'h002081B3;
        tick(2);
        RST = 1'b0;
        check_reset_values("reset");

        // Single-word program.
        pulse_start();
        check("t1_hdr_ready", 32'(byte_ready), 32'd1);
        send_byte(8'h00);
        send_word(6'd0, 32'h00000013);
        stop();
        check("t1_wr_en", 32'(wr_en), 32'd1);
        check("t1_hold_during_wr", 32'(core_hold), 32'd1);
        tick();
        check("t1_done", 32'(done), 32'd1);
        check("t1_core_hold", 32'(core_hold), 32'd0);
        check("t1_word_count", 32'(word_count), 32'd1);

        // Three words streamed back to back; one bubble per word.
        pulse_start();
        send_byte(8'h02);
        for (int i = 0; i < 3; i++) begin
            send_word(6'(i), prog[i]);
            check("t2_bubble", 32'(byte_ready), 32'd0);
            if (i < 2) begin
                tick();
                check("t2_ready_back", 32'(byte_ready), 32'd1);
            end
        end
        stop();
        wait_done("t2");
        check("t2_word_count", 32'(word_count), 32'd3);

        // Full-depth program of 64 words.
        pulse_start();
        send_byte(8'h3F);
        for (int i = 0; i < 64; i++) begin
            send_word(6'(i), {8'hA5, 8'(i), 8'(~i), 8'(i * 3)});
        end
        stop();
        wait_done("t3");
        check("t3_error", 32'(error), 32'd0);
        check("t3_word_count", 32'(word_count), 32'd64);
        check("t3_last_addr", 32'(wr_addr), 32'd63);

        // Oversized headers go to ERR; start recovers.
        pulse_start();
        send_byte(8'h40);
        stop();
        check("t4_error", 32'(error), 32'd1);
        check("t4_core_hold", 32'(core_hold), 32'd1);
        check("t4_ready", 32'(byte_ready), 32'd0);
        tick(3);
        check("t4_error_held", 32'(error), 32'd1);
        pulse_start();
        check("t4_error_cleared", 32'(error), 32'd0);
        check("t4_hdr_ready", 32'(byte_ready), 32'd1);
        send_byte(8'hFF);
        stop();
        check("t4_error_256", 32'(error), 32'd1);
        pulse_start();
        send_byte(8'h00);
        send_word(6'd0, 32'h11223344);
        stop();
        wait_done("t4");

        // Reset mid-load drops the partial word; start is ignored in DATA.
        pulse_start();
        send_byte(8'h01);
        send_word(6'd0, 32'h01020304);
        send_byte(8'hAA);
        send_byte(8'hBB);
        stop();
        pulse_start();
        check("t5_start_ignored", 32'(byte_ready), 32'd1);
        check("t5_wr_addr", 32'(wr_addr), 32'd1);
        check("t5_hold_mid", 32'(core_hold), 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_reset_values("t5_rst");
        RST   = 1'b1;
        start = 1'b1;
        tick();
        RST   = 1'b0;
        start = 1'b0;
        check("t5_rst_wins", 32'(byte_ready), 32'd0);
        pulse_start();
        send_byte(8'h00);
        send_word(6'd0, 32'hCAFEF00D);
        stop();
        wait_done("t5");
        check("t5_word_count", 32'(word_count), 32'd1);

        // Reload after DONE with a mid-word stall.
        pulse_start();
        check("t6_hold_on_start", 32'(core_hold), 32'd1);
        check("t6_done_cleared", 32'(done), 32'd0);
        send_byte(8'h00);
        exp_q.push_back({6'd0, 32'hDEADBEEF});
        send_byte(8'hEF);
        send_byte(8'hBE);
        stop();
        tick(4);
        check("t6_stall_ready", 32'(byte_ready), 32'd1);
        check("t6_stall_no_wr", 32'(wr_en), 32'd0);
        send_byte(8'hAD);
        send_byte(8'hDE);
        stop();
        wait_done("t6");
        check("t6_word_count", 32'(word_count), 32'd1);

        tick(2);
        check("final_pending", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
